pwm_capture: RTL and testbench
==============================

# pwm_capture

PWM capture block: the receive-side counterpart of the board PWM generator. It samples an asynchronous PWM input, measures high time and period in `clk` cycles, and reports an 8-bit duty value on the same 0..255 scale the generator's `sw` setting uses. It sits between a pin (or a generator output in loopback) and status/readback logic, and flags a stuck (edge-less) input.

## Interface
- `CNT_W`, 20: width of the high/period counters (saturating).
- `TIMEOUT`, 1000000: cycles since the last detected edge before the input is declared stuck. Must be less than 2**CNT_W − 1.

- `clk`  input  1  sole clock, all state on posedge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `pwm_in`  input  1  asynchronous PWM input.
- `high_cnt`  output  CNT_W  last measured high time in cycles; reset 0.
- `period_cnt`  output  CNT_W  last measured period in cycles; reset 0.
- `meas_valid`  output  1  one-cycle pulse when `high_cnt`/`period_cnt` update; reset 0.
- `duty`  output  8  floor(high_cnt*256/period_cnt); reset 0.
- `duty_valid`  output  1  one-cycle pulse when `duty` updates; reset 0.
- `stuck`  output  1  level; input has had no edge for TIMEOUT cycles; reset 0.
- `stuck_level`  output  1  synchronized `pwm_in` level latched at timeout; reset 0.

## Operation
- Input: two-flop synchronizer (reset 0), then a registered copy for edge detection; rise/fall = 1-cycle strobes.
- FSM states:
  - ARM (reset state): wait for rise → HIGH; counter cleared.
  - HIGH: counter increments; fall → snapshot counter as pending high time → LOW.
  - LOW: counter increments; rise → publish high_cnt = pending high, period_cnt = cycles since previous rise; pulse meas_valid; clear `stuck`; counter restarts → HIGH.
- For pwm_in held high H cycles and low L cycles (H, L ≥ 2): high_cnt = H, period_cnt = H + L exactly.
- Counter saturates at all-ones; never wraps.
- Timeout: counter reaching TIMEOUT in any state (including ARM) → `stuck`=1, `stuck_level` = synchronized level, FSM → ARM, no meas_valid. With the duty feature: duty = 8'h00 if stuck low, 8'hFF if stuck high, with a duty_valid pulse. `stuck` stays set until the next meas_valid.
- First rise after reset or after timeout never produces a measurement; the first meas_valid needs one full period.
- Duty divider: restoring, one quotient bit per cycle, numerator high_cnt·256 (CNT_W+8 bits), denominator period_cnt. high_cnt < period_cnt always, so the result fits in 8 bits and needs no clamp.
- A meas_valid while the divider is busy does not restart it. That sample's duty is dropped; high_cnt/period_cnt still update.
- rst_n low at any time: all outputs and state return to reset values immediately; an in-flight divide is abandoned.

## Timing
- pwm_in change → edge strobe: 3 clk edges (2 sync + 1 detect).
- Rise strobe → meas_valid high on the next cycle; high_cnt/period_cnt valid in that same cycle.
- meas_valid → duty_valid: 9 cycles (8 iterations + 1 output register); duty updates in the duty_valid cycle.
- Timeout → `stuck` set on the cycle after the counter equals TIMEOUT.
- Timeout and edge in the same cycle: the edge wins and no timeout occurs.

## Configuration
- `PWM_CAPTURE_DUTY_EN` defined: divider present; duty/duty_valid behave as above.
- Not defined: no divider logic; duty tied to 8'h00, duty_valid tied to 0. high_cnt, period_cnt, meas_valid and stuck are unchanged.

## Test plan
- Reset: hold rst_n low with pwm_in toggling → all outputs 0; release → no meas_valid before the second rise.
- Steady H=64, L=192 → high_cnt=64, period_cnt=256; duty=64 nine cycles after each meas_valid.
- Duty sweep H ∈ {2, 128, 254}, period 256 → duty = 2, 128, 254; period_cnt = 256 every time.
- TIMEOUT=1000, pwm_in held low 1200 cycles → stuck=1, stuck_level=0, duty=0. Then a valid period → stuck=0 with the measurement.
- Held high past TIMEOUT → stuck=1, stuck_level=1, duty=8'hFF.
- Period 6 (H=3, L=3) back-to-back → every meas_valid has 3/6; duty_valid only for accepted samples, duty=128. Assert rst_n mid-divide → duty_valid never fires for that divide.

Source files
------------

// File: rtl/pwm_capture_if.sv
// pwm_capture_if: PWM input pin plus measurement/status outputs of pwm_capture.
// master = driver/observer side, slave = the capture block.
interface pwm_capture_if #(
  parameter int CNT_W = 20
);
  logic             pwm_in;
  logic [CNT_W-1:0] high_cnt;
  logic [CNT_W-1:0] period_cnt;
  logic             meas_valid;
  logic [7:0]       duty;
  logic             duty_valid;
  logic             stuck;
  logic             stuck_level;

  modport master (
    output pwm_in,
    input  high_cnt, period_cnt, meas_valid, duty, duty_valid, stuck, stuck_level
  );

  modport slave (
    input  pwm_in,
    output high_cnt, period_cnt, meas_valid, duty, duty_valid, stuck, stuck_level
  );
endinterface

// File: rtl/pwm_capture.sv
// pwm_capture: measures high time and period of an asynchronous PWM input,
// flags an edge-less (stuck) input, and optionally derives an 8-bit duty.
// Optional feature macro: PWM_CAPTURE_DUTY_EN (restoring duty divider).
module pwm_capture #(
  parameter int CNT_W   = 20,
  parameter int TIMEOUT = 1000000
) (
  input  logic           clk,
  input  logic           rst_n,
  pwm_capture_if.slave   bus
);

  localparam logic [1:0] ARM  = 2'd0;
  localparam logic [1:0] HIGH = 2'd1;
  localparam logic [1:0] LOW  = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             s1, s2, s3;
  logic             rise, fall, edge_det, timeout;
  logic [1:0]       state;
  logic [CNT_W-1:0] cnt, cnt_inc, pend_high;
  logic [CNT_W-1:0] high_cnt, period_cnt;
  logic             meas_valid, stuck, stuck_level;

  // two-flop synchronizer plus a delayed copy for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= bus.pwm_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise     = s2 & ~s3;
  assign fall     = ~s2 & s3;
  assign edge_det = rise | fall;
  assign cnt_inc  = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
  // >= rather than == so a fall landing exactly on TIMEOUT cannot push the
  // counter past the compare value and hide a later stall; an edge always wins
  assign timeout  = (cnt >= TO_VAL) && !edge_det;

  // measurement FSM: counter starts at 1 on a rise so that at the next fall
  // it holds H and at the next rise it holds H+L
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ARM;
      cnt         <= '0;
      pend_high   <= '0;
      high_cnt    <= '0;
      period_cnt  <= '0;
      meas_valid  <= 1'b0;
      stuck       <= 1'b0;
      stuck_level <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      if (timeout) begin
        state       <= ARM;
        cnt         <= '0;
        stuck       <= 1'b1;
        stuck_level <= s2;
      end else begin
        case (state)
          ARM: begin
            if (rise) begin
              state <= HIGH;
              cnt   <= CNT_ONE;
            end else if (fall) begin
              cnt <= '0;
            end else begin
              cnt <= cnt_inc;
            end
          end
          HIGH: begin
            cnt <= cnt_inc;
            if (fall) begin
              pend_high <= cnt;
              state     <= LOW;
            end
          end
          LOW: begin
            if (rise) begin
              high_cnt   <= pend_high;
              period_cnt <= cnt;
              meas_valid <= 1'b1;
              stuck      <= 1'b0;
              cnt        <= CNT_ONE;
              state      <= HIGH;
            end else begin
              cnt <= cnt_inc;
            end
          end
          default: begin
            state <= ARM;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign bus.high_cnt    = high_cnt;
  assign bus.period_cnt  = period_cnt;
  assign bus.meas_valid  = meas_valid;
  assign bus.stuck       = stuck;
  assign bus.stuck_level = stuck_level;

`ifdef PWM_CAPTURE_DUTY_EN
  localparam int STAGES = 7;

  // remainder starts at high_cnt (< period_cnt) and is doubled each step,
  // which is the same as dividing high_cnt*256 one quotient bit at a time
  logic [STAGES:0]  vld_pipe;
  logic [CNT_W:0]   rem, rem2, rem_nxt;
  logic [CNT_W-1:0] den;
  logic [7:0]       quo, quo_nxt, duty;
  logic             ge, duty_valid;

  assign rem2    = {rem[CNT_W-1:0], 1'b0};
  assign ge      = rem2 >= {1'b0, den};
  assign rem_nxt = ge ? rem2 - {1'b0, den} : rem2;
  assign quo_nxt = {quo[6:0], ge};

  // iterative divider; a sample arriving while busy is ignored, and a
  // timeout overrides the output with the stuck level's duty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe   <= '0;
      rem        <= '0;
      den        <= '0;
      quo        <= '0;
      duty       <= '0;
      duty_valid <= 1'b0;
    end else begin
      duty_valid <= 1'b0;
      vld_pipe   <= {vld_pipe[STAGES-1:0], 1'b0};
      if (|vld_pipe) begin
        rem <= rem_nxt;
        quo <= quo_nxt;
        if (vld_pipe[STAGES]) begin
          duty       <= quo_nxt;
          duty_valid <= 1'b1;
        end
      end else if (meas_valid) begin
        rem      <= {1'b0, high_cnt};
        den      <= period_cnt;
        quo      <= '0;
        vld_pipe <= {{STAGES{1'b0}}, 1'b1};
      end
      if (timeout) begin
        duty       <= s2 ? 8'hFF : 8'h00;
        duty_valid <= 1'b1;
      end
    end
  end

  assign bus.duty       = duty;
  assign bus.duty_valid = duty_valid;
`else
  assign bus.duty       = 8'h00;
  assign bus.duty_valid = 1'b0;
`endif

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed + randomized PWM waveforms; expectations come from
// the driven high/low lengths (H, H+L, floor(H*256/(H+L))) and a cycle-level
// model of which samples the busy divider accepts.
module tb_pwm_capture;
  localparam int CNT_W   = 20;
  localparam int TIMEOUT = 1000;
`ifdef PWM_CAPTURE_DUTY_EN
  localparam bit DUTY_EN = 1'b1;
`else
  localparam bit DUTY_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;

  int m_cyc[$], m_hi[$], m_per[$], d_cyc[$], d_val[$];
  int ph[$], pl[$], rise_cyc[$];

  pwm_capture_if #(.CNT_W(CNT_W)) bus ();

  pwm_capture #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // record output events away from the active edge
  always @(negedge clk) begin
    if (bus.meas_valid === 1'b1) begin
      m_cyc.push_back(cyc);
      m_hi.push_back(int'(bus.high_cnt));
      m_per.push_back(int'(bus.period_cnt));
    end
    if (bus.duty_valid === 1'b1) begin
      d_cyc.push_back(cyc);
      d_val.push_back(int'(bus.duty));
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_events();
    m_cyc.delete(); m_hi.delete(); m_per.delete();
    d_cyc.delete(); d_val.delete(); rise_cyc.delete();
  endtask

  task automatic do_reset();
    bus.pwm_in = 1'b0;
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(3);
    clear_events();
  endtask

  task automatic drive(input int h, input int l);
    bus.pwm_in = 1'b1;
    rise_cyc.push_back(cyc);
    tick(h);
    bus.pwm_in = 1'b0;
    tick(l);
  endtask

  // drive every queued period, finish with one more rise, then compare
  task automatic run_seq(input string tag);
    int n, last, c;
    int e_cyc[$], e_val[$];
    do_reset();
    tick(4);
    foreach (ph[i]) drive(ph[i], pl[i]);
    bus.pwm_in = 1'b1;
    rise_cyc.push_back(cyc);
    tick(20);
    n = ph.size();
    check({tag, "_meas_count"}, 32'(m_cyc.size()), 32'(n));
    last = -1000;
    for (int k = 0; k < n; k++) begin
      c = rise_cyc[k + 1] + 3;
      if (k < m_cyc.size()) begin
        check({tag, "_high"}, 32'(m_hi[k]), 32'(ph[k]));
        check({tag, "_period"}, 32'(m_per[k]), 32'(ph[k] + pl[k]));
        check({tag, "_meas_cycle"}, 32'(m_cyc[k]), 32'(c));
      end
      if (DUTY_EN && (c - last >= 9)) begin
        last = c;
        e_cyc.push_back(c + 9);
        e_val.push_back((ph[k] * 256) / (ph[k] + pl[k]));
      end
    end
    check({tag, "_duty_count"}, 32'(d_cyc.size()), 32'(e_cyc.size()));
    for (int k = 0; k < e_cyc.size() && k < d_cyc.size(); k++) begin
      check({tag, "_duty"}, 32'(d_val[k]), 32'(e_val[k]));
      check({tag, "_duty_cycle"}, 32'(d_cyc[k]), 32'(e_cyc[k]));
    end
    ph.delete();
    pl.delete();
  endtask

  initial begin
    bus.pwm_in = 1'b0;

    // reset held while the input toggles: everything stays at zero
    for (int i = 0; i < 20; i++) begin
      bus.pwm_in = 1'($urandom_range(1, 0));
      tick(1);
    end
    check("rst_high_cnt", 32'(bus.high_cnt), 32'd0);
    check("rst_period_cnt", 32'(bus.period_cnt), 32'd0);
    check("rst_meas_valid", 32'(bus.meas_valid), 32'd0);
    check("rst_duty", 32'(bus.duty), 32'd0);
    check("rst_duty_valid", 32'(bus.duty_valid), 32'd0);
    check("rst_stuck", 32'(bus.stuck), 32'd0);
    check("rst_stuck_level", 32'(bus.stuck_level), 32'd0);

    // steady 64/192
    for (int i = 0; i < 4; i++) begin ph.push_back(64); pl.push_back(192); end
    run_seq("steady");

    // duty sweep at period 256
    ph.push_back(2);   pl.push_back(254);
    ph.push_back(128); pl.push_back(128);
    ph.push_back(254); pl.push_back(2);
    run_seq("sweep");

    // random high/low lengths
    for (int i = 0; i < 8; i++) begin
      ph.push_back(int'($urandom_range(300, 2)));
      pl.push_back(int'($urandom_range(300, 2)));
    end
    run_seq("random");

    // back-to-back period 6: divider busy drops alternate samples
    for (int i = 0; i < 10; i++) begin ph.push_back(3); pl.push_back(3); end
    run_seq("p6");

    // held low past TIMEOUT
    do_reset();
    tick(990);
    check("lo_not_yet_stuck", 32'(bus.stuck), 32'd0);
    tick(210);
    check("lo_stuck", 32'(bus.stuck), 32'd1);
    check("lo_stuck_level", 32'(bus.stuck_level), 32'd0);
    check("lo_duty", 32'(bus.duty), 32'd0);
    check("lo_meas_count", 32'(m_cyc.size()), 32'd0);
    check("lo_duty_events", 32'(d_cyc.size()), 32'(DUTY_EN ? 1 : 0));
    foreach (d_val[i]) check("lo_duty_event_val", 32'(d_val[i]), 32'd0);
    drive(50, 150);
    check("lo_stuck_after_first_rise", 32'(bus.stuck), 32'd1);
    bus.pwm_in = 1'b1;
    tick(6);
    check("lo_stuck_cleared", 32'(bus.stuck), 32'd0);
    check("lo_recover_count", 32'(m_cyc.size()), 32'd1);
    if (m_cyc.size() > 0) begin
      check("lo_recover_high", 32'(m_hi[0]), 32'd50);
      check("lo_recover_period", 32'(m_per[0]), 32'd200);
    end

    // held high past TIMEOUT, then asynchronous reset mid-cycle
    do_reset();
    bus.pwm_in = 1'b1;
    tick(1200);
    check("hi_stuck", 32'(bus.stuck), 32'd1);
    check("hi_stuck_level", 32'(bus.stuck_level), 32'd1);
    check("hi_duty", 32'(bus.duty), 32'(DUTY_EN ? 255 : 0));
    check("hi_meas_count", 32'(m_cyc.size()), 32'd0);
    rst_n = 1'b0;
    #1;
    check("async_rst_stuck", 32'(bus.stuck), 32'd0);
    check("async_rst_stuck_level", 32'(bus.stuck_level), 32'd0);
    check("async_rst_duty", 32'(bus.duty), 32'd0);

    // reset asserted while a divide is in flight
    do_reset();
    tick(4);
    drive(3, 3);
    bus.pwm_in = 1'b1;
    tick(7);
    rst_n = 1'b0;
    tick(2);
    check("middiv_meas_count", 32'(m_cyc.size()), 32'd1);
    rst_n = 1'b1;
    tick(15);
    check("middiv_no_duty", 32'(d_cyc.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
